// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register busy
// scoreboard. Reads are combinational, with optional same-cycle forwarding
// of write data and busy-clear. pending_cnt holds the number of registers
// that still have an outstanding producer.
module regfile_sb #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int ZERO_REG_EN = 1,
    parameter int BYPASS_EN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [ADDR_W:0]     cnt_nxt;

    logic we_ok;
    logic iss_ok;
    logic zero1, zero2;
    logic hit1, hit2;
    logic iss_hit1, iss_hit2;

    // A write or an issue aimed at the hardwired zero register does nothing.
    // The write qualifier is also gated by rst_n so that, while reset is
    // held, the bypass path cannot expose wdata on the read ports.
    assign we_ok  = we && rst_n && !((ZERO_REG_EN != 0) && (waddr == '0));
    assign iss_ok = issue_en && !((ZERO_REG_EN != 0) && (issue_addr == '0));

    // Next busy vector: flush wipes everything, a write clears its bit, and
    // a same-cycle issue is applied last, so the new producer always wins.
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        if (we_ok) begin
            busy_nxt[waddr] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[issue_addr] = 1'b1;
        end
    end

    // pending_cnt is a popcount of the post-update busy vector, so it can
    // neither double count a reissue nor underflow.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
        end
    end

    // Register data, busy bits and pending count; all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            if (we_ok) begin
                regs[waddr] <= wdata;
            end
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    assign zero1    = (ZERO_REG_EN != 0) && (raddr1 == '0);
    assign zero2    = (ZERO_REG_EN != 0) && (raddr2 == '0);
    assign hit1     = (BYPASS_EN != 0) && we_ok && (waddr == raddr1);
    assign hit2     = (BYPASS_EN != 0) && we_ok && (waddr == raddr2);
    assign iss_hit1 = iss_ok && (issue_addr == raddr1);
    assign iss_hit2 = iss_ok && (issue_addr == raddr2);

    // A forwarded busy-clear is suppressed when the same address is being
    // reissued this cycle; the registered busy bit is shown instead.
    assign rdata1 = zero1 ? '0 : (hit1 ? wdata : regs[raddr1]);
    assign rdata2 = zero2 ? '0 : (hit2 ? wdata : regs[raddr2]);
    assign rbusy1 = zero1 ? 1'b0 : ((hit1 && !iss_hit1) ? 1'b0 : busy[raddr1]);
    assign rbusy2 = zero2 ? 1'b0 : ((hit2 && !iss_hit2) ? 1'b0 : busy[raddr2]);

endmodule
